// File: rtl/tap_state_controller.sv
`timescale 1ns/1ps
// IEEE 1149.1 TAP controller: 16-state FSM on rising tck, IR/DR strobes, TDO mux/enable, RTI cycle counter.
// Decodes are combinational; update/select/enable/test_reset come from falling-tck registers. There is no backpressure: tck/tms only.
module tap_state_controller #(
  parameter int IDLE_CNT_W = 16
) (
  input  logic                  tck,
  input  logic                  tl_reset,
  input  logic                  tms,
  output logic [3:0]            state,
  output logic                  test_reset,
  output logic                  capture_ir,
  output logic                  shift_ir,
  output logic                  update_ir,
  output logic                  capture_dr,
  output logic                  shift_dr,
  output logic                  update_dr,
  output logic                  select_ir,
  output logic                  tdo_en,
  output logic [IDLE_CNT_W-1:0] idle_count
);

  typedef enum logic [3:0] {
    EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PSDR  = 4'h3,
    SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
    EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PSIR  = 4'hB,
    RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
  } tap_state_e;

  localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = {IDLE_CNT_W{1'b1}};

  tap_state_e            r_state;
  tap_state_e            w_next;
  logic                  r_upd_ir;
  logic                  r_upd_dr;
  logic                  r_sel_ir;
  logic                  r_tdo_en;
  logic                  r_test_reset;
  logic [IDLE_CNT_W-1:0] r_idle_count;
  logic                  w_in_ir_col;

  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) r_state <= TLR;
    else          r_state <= w_next;
  end

  // if/else (not ?:) so an X on tms picks a branch instead of propagating into state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      TLR:   if (tms) w_next = TLR;   else w_next = RTI;
      RTI:   if (tms) w_next = SELDR; else w_next = RTI;
      SELDR: if (tms) w_next = SELIR; else w_next = CAPDR;
      SELIR: if (tms) w_next = TLR;   else w_next = CAPIR;
      CAPDR: if (tms) w_next = EX1DR; else w_next = SHDR;
      SHDR:  if (tms) w_next = EX1DR; else w_next = SHDR;
      EX1DR: if (tms) w_next = UPDDR; else w_next = PSDR;
      PSDR:  if (tms) w_next = EX2DR; else w_next = PSDR;
      EX2DR: if (tms) w_next = UPDDR; else w_next = SHDR;
      UPDDR: if (tms) w_next = SELDR; else w_next = RTI;
      CAPIR: if (tms) w_next = EX1IR; else w_next = SHIR;
      SHIR:  if (tms) w_next = EX1IR; else w_next = SHIR;
      EX1IR: if (tms) w_next = UPDIR; else w_next = PSIR;
      PSIR:  if (tms) w_next = EX2IR; else w_next = PSIR;
      EX2IR: if (tms) w_next = UPDIR; else w_next = SHIR;
      UPDIR: if (tms) w_next = SELDR; else w_next = RTI;
      default: w_next = TLR;
    endcase
  end

  always_comb begin
    state       = r_state;
    capture_ir  = (r_state == CAPIR);
    shift_ir    = (r_state == SHIR);
    capture_dr  = (r_state == CAPDR);
    shift_dr    = (r_state == SHDR);
    update_ir   = r_upd_ir & ~tck;
    update_dr   = r_upd_dr & ~tck;
    select_ir   = r_sel_ir;
    tdo_en      = r_tdo_en;
    test_reset  = r_test_reset;
    idle_count  = r_idle_count;
    w_in_ir_col = (r_state == TLR) || (r_state == SELIR) || (r_state == CAPIR) ||
                  (r_state == SHIR) || (r_state == EX1IR) || (r_state == PSIR) ||
                  (r_state == EX2IR) || (r_state == UPDIR);
  end

  // Falling-tck registers: stable across the rising edge that consumes them
  always_ff @(negedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      r_upd_ir     <= 1'b0;
      r_upd_dr     <= 1'b0;
      r_sel_ir     <= 1'b1;
      r_tdo_en     <= 1'b0;
      r_test_reset <= 1'b1;
    end else begin
      r_upd_ir     <= (r_state == UPDIR);
      r_upd_dr     <= (r_state == UPDDR);
      r_sel_ir     <= w_in_ir_col;
      r_tdo_en     <= (r_state == SHIR) || (r_state == SHDR);
      r_test_reset <= (r_state == TLR);
    end
  end

  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      r_idle_count <= '0;
    end else if ((w_next == RTI) && (r_state != RTI)) begin
      r_idle_count <= '0;
    end else if ((r_state == RTI) && !tms && (r_idle_count != IDLE_MAX)) begin
      r_idle_count <= r_idle_count + 1'b1;
    end
  end

  a_tms_known: assert property (@(posedge tck) disable iff (tl_reset) !$isunknown(tms))
    else $error("tms unknown at rising tck");

endmodule

// File: tb/tb_tap_state_controller.sv
`timescale 1ns/1ps
// Self-checking bench for tap_state_controller: spec transition table model, vector tables, random walk.
module tb_tap_state_controller;

  localparam int W    = 3;
  localparam int MAXC = (1 << W) - 1;
  localparam int S_TLR = 15, S_RTI = 12, S_SHDR = 2, S_SHIR = 10, S_UPDDR = 5, S_UPDIR = 13;

  logic         tck = 1'b0;
  logic         tl_reset = 1'b1;
  logic         tms = 1'b1;
  logic [3:0]   state;
  logic         test_reset, capture_ir, shift_ir, update_ir;
  logic         capture_dr, shift_dr, update_dr, select_ir, tdo_en;
  logic [W-1:0] idle_count;

  tap_state_controller #(.IDLE_CNT_W(W)) dut (
    .tck(tck), .tl_reset(tl_reset), .tms(tms), .state(state),
    .test_reset(test_reset), .capture_ir(capture_ir), .shift_ir(shift_ir),
    .update_ir(update_ir), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .select_ir(select_ir), .tdo_en(tdo_en),
    .idle_count(idle_count)
  );

  always #5 tck = ~tck;

  typedef struct {
    bit tms;
    int st;
    int idle;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   nxt0 [16];
  int   nxt1 [16];
  int   m_state = S_TLR;
  int   m_cnt = 0;
  int   n_cap_ir, n_sh_ir, n_upd_ir, n_upd_dr;
  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic bit is_ir_col(input int s);
    return s inside {15, 4, 14, 10, 9, 11, 8, 13};
  endfunction

  function automatic bit is_shift(input int s);
    return (s == S_SHDR) || (s == S_SHIR);
  endfunction

  // Called in the low phase; checks one full tck period against the model
  task automatic step(input bit t);
    int ps;
    tms = t;
    @(posedge tck);
    ps = m_state;
    m_state = t ? nxt1[ps] : nxt0[ps];
    if (m_state == S_RTI && ps != S_RTI) m_cnt = 0;
    else if (ps == S_RTI && !t && m_cnt < MAXC) m_cnt++;
    #1;
    chk("state", state, m_state);
    chk("capture_ir", capture_ir, m_state == 14);
    chk("shift_ir", shift_ir, m_state == S_SHIR);
    chk("capture_dr", capture_dr, m_state == 6);
    chk("shift_dr", shift_dr, m_state == S_SHDR);
    chk("idle_count", idle_count, m_cnt);
    chk("update_ir_hi", update_ir, 0);
    chk("update_dr_hi", update_dr, 0);
    chk("tdo_en_hi", tdo_en, is_shift(ps));
    chk("select_ir_hi", select_ir, is_ir_col(ps));
    chk("test_reset_hi", test_reset, ps == S_TLR);
    n_cap_ir += capture_ir;
    n_sh_ir  += shift_ir;
    @(negedge tck);
    #1;
    chk("update_ir_lo", update_ir, m_state == S_UPDIR);
    chk("update_dr_lo", update_dr, m_state == S_UPDDR);
    chk("tdo_en_lo", tdo_en, is_shift(m_state));
    chk("select_ir_lo", select_ir, is_ir_col(m_state));
    chk("test_reset_lo", test_reset, m_state == S_TLR);
    n_upd_ir += update_ir;
    n_upd_dr += update_dr;
  endtask

  task automatic do_reset();
    tl_reset = 1'b1;
    #1;
    chk("rst_state", state, S_TLR);
    chk("rst_test_reset", test_reset, 1);
    chk("rst_select_ir", select_ir, 1);
    chk("rst_tdo_en", tdo_en, 0);
    chk("rst_update_ir", update_ir, 0);
    chk("rst_update_dr", update_dr, 0);
    chk("rst_shift_dr", shift_dr, 0);
    chk("rst_idle", idle_count, 0);
    #1;
    tl_reset = 1'b0;
    m_state = S_TLR;
    m_cnt = 0;
  endtask

  task automatic clr_counts();
    n_cap_ir = 0; n_sh_ir = 0; n_upd_ir = 0; n_upd_dr = 0;
  endtask

  task automatic add(input bit t, input int st, input int idle);
    vec_t v;
    v.tms = t; v.st = st; v.idle = idle;
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input string nm);
    foreach (vecs[i]) begin
      step(vecs[i].tms);
      chk({nm, "_state"}, state, vecs[i].st);
      if (vecs[i].idle >= 0) chk({nm, "_idle"}, idle_count, vecs[i].idle);
    end
    vecs.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // transition table taken straight from the (tms=0 / tms=1) list
    nxt0[15]=12; nxt1[15]=15;  nxt0[12]=12; nxt1[12]=7;
    nxt0[7]=6;   nxt1[7]=4;    nxt0[4]=14;  nxt1[4]=15;
    nxt0[6]=2;   nxt1[6]=1;    nxt0[2]=2;   nxt1[2]=1;
    nxt0[1]=3;   nxt1[1]=5;    nxt0[3]=3;   nxt1[3]=0;
    nxt0[0]=2;   nxt1[0]=5;    nxt0[5]=12;  nxt1[5]=7;
    nxt0[14]=10; nxt1[14]=9;   nxt0[10]=10; nxt1[10]=9;
    nxt0[9]=11;  nxt1[9]=13;   nxt0[11]=11; nxt1[11]=8;
    nxt0[8]=10;  nxt1[8]=13;   nxt0[13]=12; nxt1[13]=7;

    @(negedge tck); #1;
    do_reset();

    // T4 + T1: walk into SHIFT_DR, shift, then reset while tdo_en is high
    add(0, 12, 0); add(1, 7, 0); add(0, 6, 0); add(0, 2, 0); add(0, 2, 0);
    run_vecs("t4");
    chk("t1_tdo_en_before", tdo_en, 1);
    do_reset();

    // T3: IR scan with 4 shift cycles and one update
    clr_counts();
    add(0,12,0); add(1,7,0); add(1,4,0); add(0,14,0); add(0,10,0); add(0,10,0);
    add(0,10,0); add(0,10,0); add(1,9,0); add(1,13,0); add(0,12,0);
    run_vecs("t3");
    chk("t3_capture_ir_cycles", n_cap_ir, 1);
    chk("t3_shift_ir_cycles", n_sh_ir, 4);
    chk("t3_update_ir_pulses", n_upd_ir, 1);

    // T5: saturating idle counter, restart after leaving RTI
    do_reset();
    add(0, 12, 0);
    for (int i = 1; i <= 10; i++) add(0, 12, (i > MAXC) ? MAXC : i);
    add(1, 7, MAXC); add(1, 4, MAXC); add(1, 15, MAXC); add(0, 12, 0); add(0, 12, 1);
    run_vecs("t5");

    // T6: PAUSE_IR loop then back to SHIFT_IR, no update
    clr_counts();
    add(1,7,-1); add(1,4,-1); add(0,14,-1); add(0,10,-1); add(1,9,-1); add(0,11,-1);
    add(0,11,-1); add(0,11,-1); add(1,8,-1); add(0,10,-1);
    run_vecs("t6");
    chk("t6_shift_ir", shift_ir, 1);
    chk("t6_update_ir_pulses", n_upd_ir, 0);

    // T2: five tms=1 edges from every state reach TLR
    for (int tgt = 0; tgt < 16; tgt++) begin
      int n = 0;
      while (m_state != tgt && n < 300) begin
        step(1'($urandom_range(0, 1)));
        n++;
      end
      chk("t2_reach", m_state == tgt, 1);
      for (int k = 0; k < 5; k++) step(1);
      chk("t2_tlr", state, S_TLR);
    end

    // Random walk with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      else step(1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
